add_seq_arb: RTL and testbench

Controller and two-port arbiter for the shared 4-bit pipelined-carry ripple adder (`ripplecarry4_clk`). Two requesters submit multi-word operands. The block grants one requester round-robin and sequences the operation nibble by nibble through the adder. For each nibble it holds the adder inputs stable until the registered internal carries settle, then captures the result and chains the carry-out into the next nibble. The full-width result is returned on a valid/ready response channel tagged with the requester id.

---
 rtl/add_seq_arb.sv | 161 ++++++++++++++++
 tb/tb_add_seq_arb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_arb.sv
// Round-robin two-port sequencer for the shared 4-bit pipelined-carry adder.
// Define ADD_SEQ_SUB_EN to enable A-B (two's complement) requests.
module add_seq_arb #(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned SETTLE  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req0_sub,
    input  logic                 req1_sub,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [4*NIBBLES-1:0] resp_sum,
    output logic                 resp_cout,
    output logic                 resp_id
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StCapt, StDone} state_e;

    state_e        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          last_grant;
    logic          id;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  result;

    logic          grant_valid;
    logic          grant_id;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic [3:0]    first_b;
    logic [3:0]    next_b;
    logic          first_cin;

    assign grant_valid = req0_valid | req1_valid;
    // On a tie the requester that did not win last time gets the grant.
    assign grant_id    = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign sel_a       = grant_id ? req1_a : req0_a;
    assign sel_b       = grant_id ? req1_b : req0_b;
    assign req0_ready  = !rst && (state == StIdle) && grant_valid && !grant_id;
    assign req1_ready  = !rst && (state == StIdle) && grant_valid && grant_id;

`ifdef ADD_SEQ_SUB_EN
    logic sub_q;
    logic sel_sub;

    assign sel_sub   = grant_id ? req1_sub : req0_sub;
    assign first_b   = sel_b[3:0] ^ {4{sel_sub}};
    assign first_cin = sel_sub;
    assign next_b    = b_sh[3:0] ^ {4{sub_q}};

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (state == StIdle && grant_valid) begin
            sub_q <= sel_sub;
        end
    end
`else
    logic unused_sub;

    assign unused_sub = req0_sub ^ req1_sub;
    assign first_b    = sel_b[3:0];
    assign first_cin  = 1'b0;
    assign next_b     = b_sh[3:0];
`endif

    assign resp_sum  = result;
    assign resp_cout = carry;
    assign resp_id   = id;

    // Operands are consumed low nibble first from shift registers; the result fills from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            idx        <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            last_grant <= 1'b1;
            id         <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            result     <= '0;
            add_a      <= 4'h0;
            add_b      <= 4'h0;
            add_cin    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant_valid) begin
                        a_sh       <= sel_a >> 4;
                        b_sh       <= sel_b >> 4;
                        add_a      <= sel_a[3:0];
                        add_b      <= first_b;
                        add_cin    <= first_cin;
                        carry      <= first_cin;
                        id         <= grant_id;
                        last_grant <= grant_id;
                        idx        <= '0;
                        cnt        <= '0;
                        state      <= StRun;
                    end
                end
                StRun: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SETTLE - 1)) begin
                        state <= StCapt;
                    end
                end
                StCapt: begin
                    result <= (result >> 4) | (W'(add_sum) << (W - 4));
                    carry  <= add_cout;
                    cnt    <= '0;
                    if (idx == IW'(NIBBLES - 1)) begin
                        add_a      <= 4'h0;
                        add_b      <= 4'h0;
                        add_cin    <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= StDone;
                    end else begin
                        idx     <= idx + 1'b1;
                        add_a   <= a_sh[3:0];
                        add_b   <= next_b;
                        add_cin <= add_cout;
                        a_sh    <= a_sh >> 4;
                        b_sh    <= b_sh >> 4;
                        state   <= StRun;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq_arb.sv
// Directed bench for add_seq_arb with a 3-stage pipelined 4-bit adder model.
module tb_add_seq_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_sub, req1_sub;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        resp_valid, resp_ready, resp_cout, resp_id;
    logic [15:0] resp_sum;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    add_seq_arb #(.NIBBLES(4), .SETTLE(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_sum    (add_sum),
        .add_cout   (add_cout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_id    (resp_id)
    );

    // Adder outputs become valid three edges after its inputs settle.
    logic [4:0] p1 = '0, p2 = '0, p3 = '0;
    always @(posedge clk) begin
        p1 <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
        p2 <= p1;
        p3 <= p2;
    end
    assign add_sum  = p3[3:0];
    assign add_cout = p3[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_r0"}, req0_ready, 0);
        chk({tag, "_r1"}, req1_ready, 0);
        chk({tag, "_add_a"}, add_a, 0);
        chk({tag, "_add_b"}, add_b, 0);
        chk({tag, "_cin"}, add_cin, 0);
        chk({tag, "_rv"}, resp_valid, 0);
        chk({tag, "_sum"}, resp_sum, 0);
        chk({tag, "_cout"}, resp_cout, 0);
        chk({tag, "_id"}, resp_id, 0);
    endtask

    // Called #1 after the accept edge; cins[k] is add_cin while nibble k is presented.
    task automatic wait_resp(output int lat, output logic [3:0] cins);
        lat  = 0;
        cins = 4'h0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (lat % 4 == 1 && lat < 16) cins[lat / 4] = add_cin;
        end
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({tag, "_rv_drop"}, resp_valid, 0);
    endtask

    task automatic run_op(input string tag, input bit port, input logic [15:0] a,
                          input logic [15:0] b, input logic sub, input logic [15:0] exp_sum,
                          input logic exp_cout, output logic [3:0] cins);
        int lat;
        if (port) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
        end
        #1 chk({tag, "_ready"}, port ? req1_ready : req0_ready, 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp(lat, cins);
        chk({tag, "_lat"}, lat, 16);
        chk({tag, "_sum"}, resp_sum, exp_sum);
        chk({tag, "_cout"}, resp_cout, exp_cout);
        chk({tag, "_id"}, resp_id, port);
        handshake(tag);
    endtask

    initial begin
        logic [3:0] cins;
        int         lat;
        int         seen;
        logic [15:0] held;

        rst = 1'b1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_sub = 0; req1_sub = 0;
        do_reset();
        chk_idle_outputs("reset");

        // A request presented under reset is dropped.
        rst = 1'b1;
        req0_a = 16'h000A; req0_b = 16'h0003; req0_valid = 1'b1;
        #1 chk("rst_req_ready", req0_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("rst_req_dropped", add_a, 0);

        run_op("add", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, cins);
        run_op("chain", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, cins);
        chk("chain_cins", cins, 4'b1110);
`ifdef ADD_SEQ_SUB_EN
        run_op("sub", 1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, cins);
`else
        run_op("sub", 1'b0, 16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, cins);
`endif

        // Back-pressure in DONE with a competing request waiting.
        req0_a = 16'h00F0; req0_b = 16'h0010; req0_sub = 1'b0; req0_valid = 1'b1;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        wait_resp(lat, cins);
        chk("bp_sum", resp_sum, 16'h0100);
        held = resp_sum;
        req0_a = 16'h0001; req0_b = 16'h0001; req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_rv", resp_valid, 1);
            chk("bp_hold", resp_sum, held);
            chk("bp_nogrant", req0_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        req0_valid = 1'b0;
        chk("bp_rv_drop", resp_valid, 0);
        req0_valid = 1'b1;
        #1 chk("bp_idle_ready", req0_ready, 1);
        req0_valid = 1'b0;

        // Reset during RUN of nibble 2.
        @(posedge clk);
        #1 req0_a = 16'h1234; req0_b = 16'h0FFF; req0_valid = 1'b1;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_idle_outputs("midrst");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 if (resp_valid) seen++;
        end
        chk("midrst_noresp", seen, 0);
        run_op("after_rst", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, cins);

        // Arbitration from reset.
        do_reset();
        req0_a = 16'h0011; req0_b = 16'h0022; req0_sub = 1'b0;
        req1_a = 16'h0100; req1_b = 16'h0200; req1_sub = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 chk("tie1_r0", req0_ready, 1);
        chk("tie1_r1", req1_ready, 0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        chk("busy_r1", req1_ready, 0);
        wait_resp(lat, cins);
        chk("tie1_sum", resp_sum, 16'h0033);
        chk("tie1_id", resp_id, 0);
        handshake("tie1");
        req0_valid = 1'b1;
        #1 chk("tie2_r1", req1_ready, 1);
        chk("tie2_r0", req0_ready, 0);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        wait_resp(lat, cins);
        chk("tie2_sum", resp_sum, 16'h0300);
        chk("tie2_id", resp_id, 1);
        handshake("tie2");
        req1_valid = 1'b1;
        #1 chk("tie3_r0", req0_ready, 1);
        chk("tie3_r1", req1_ready, 0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp(lat, cins);
        chk("tie3_sum", resp_sum, 16'h0033);
        chk("tie3_id", resp_id, 0);
        handshake("tie3");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
